// File: rtl/ctr_mod_updn.sv
// Modulo-N up/down counter with load, wrap or saturate at the bounds, carry pulse and sticky overflow.
// Latency: q/co/ovf update one clk after the request; tc is combinational from q and up. No backpressure.
module ctr_mod_updn #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 2 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
        $error("ctr_mod_updn: need WIDTH >= 2 and 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   ONE  = (WIDTH+1)'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   q_inc, q_dec;
    logic             at_top, at_bot;

    // One extra bit: an increment past QMAX or a borrow out of zero marks the boundary step.
    always_comb begin
        q_inc  = {1'b0, q_q} + ONE;
        q_dec  = {1'b0, q_q} - ONE;
        at_top = (q_inc > {1'b0, QMAX});
        at_bot = q_dec[WIDTH];
    end

    always_comb begin
        q_d   = q_q;
        co_d  = 1'b0;
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (clr) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (ld) begin
            if (d > QMAX) begin
                q_d   = QMAX;
                ovf_d = 1'b1;
            end else begin
                q_d = d;
            end
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    q_d   = (SATURATE != 0) ? QMAX : '0;
                    co_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    q_d = q_inc[WIDTH-1:0];
                end
            end else begin
                if (at_bot) begin
                    q_d   = (SATURATE != 0) ? '0 : QMAX;
                    co_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    q_d = q_dec[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign co  = co_q;
    assign ovf = ovf_q;
    assign tc  = up ? (q_q == QMAX) : (q_q == '0);

endmodule

// File: tb/tb_ctr_mod_updn.sv
// Bench for ctr_mod_updn: three instances (wrap/saturate at WIDTH=4 MODULUS=10, wrap at WIDTH=8 MODULUS=256)
// share control inputs and are checked every cycle against an integer reference model.
module tb_ctr_mod_updn;

    logic       clk, rst, clr, ld, en, up, ovf_clr;
    logic [3:0] d4;
    logic [7:0] d8;
    logic [3:0] q0, q1;
    logic [7:0] q2;
    logic       co0, co1, co2, tc0, tc1, tc2, ovf0, ovf1, ovf2;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 0;

    ctr_mod_updn #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d4), .en(en), .up(up), .ovf_clr(ovf_clr),
        .q(q0), .co(co0), .tc(tc0), .ovf(ovf0));
    ctr_mod_updn #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d4), .en(en), .up(up), .ovf_clr(ovf_clr),
        .q(q1), .co(co1), .tc(tc1), .ovf(ovf1));
    ctr_mod_updn #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) u_full (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d8), .en(en), .up(up), .ovf_clr(ovf_clr),
        .q(q2), .co(co2), .tc(tc2), .ovf(ovf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers, one slot per instance.
    int mod_v[3] = '{10, 10, 256};
    int sat_v[3] = '{0, 1, 0};
    int mq[3], mco[3], movf[3];
    int nv, dv;
    bit ev;

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mq[i] = 0; mco[i] = 0; movf[i] = 0;
            end else if (clr) begin
                mq[i] = 0; mco[i] = 0; movf[i] = 0;
            end else begin
                ev = 0;
                mco[i] = 0;
                if (ld) begin
                    dv = (i == 2) ? int'(d8) : int'(d4);
                    if (dv >= mod_v[i]) begin
                        mq[i] = mod_v[i] - 1;
                        ev = 1;
                    end else begin
                        mq[i] = dv;
                    end
                end else if (en) begin
                    nv = up ? mq[i] + 1 : mq[i] - 1;
                    if (nv < 0 || nv >= mod_v[i]) begin
                        ev = 1;
                        mco[i] = 1;
                        if (sat_v[i] == 0) nv = (nv + mod_v[i]) % mod_v[i];
                        else nv = mq[i];
                    end
                    mq[i] = nv;
                end
                if (ev) movf[i] = 1;
                else if (ovf_clr) movf[i] = 0;
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dq(input int i);
        case (i)
            0: dq = {28'd0, q0};
            1: dq = {28'd0, q1};
            default: dq = {24'd0, q2};
        endcase
    endfunction

    function automatic logic [31:0] dflag(input int i, input int which);
        logic [2:0] v;
        case (which)
            0: v = {co2, co1, co0};
            1: v = {tc2, tc1, tc0};
            default: v = {ovf2, ovf1, ovf0};
        endcase
        dflag = {31'd0, v[i]};
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                cmp($sformatf("model i%0d q", i), dq(i), mq[i]);
                cmp($sformatf("model i%0d co", i), dflag(i, 0), mco[i]);
                cmp($sformatf("model i%0d tc", i), dflag(i, 1),
                    up ? int'(mq[i] == mod_v[i] - 1) : int'(mq[i] == 0));
                cmp($sformatf("model i%0d ovf", i), dflag(i, 2), movf[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 0; ld = 0; en = 0; up = 1; ovf_clr = 0; d4 = 0; d8 = 0;
        step();
        step();
        chk_on = 1;
        cmp("reset q", dq(0), 0);
        cmp("reset co", co0, 0);
        cmp("reset ovf", ovf0, 0);
        cmp("reset tc up", tc0, 0);
        rst = 1'b0;

        // Up count with wrap at 9 -> 0
        en = 1; up = 1;
        for (int k = 1; k <= 12; k++) begin
            step();
            cmp($sformatf("wrap q k%0d", k), dq(0), k % 10);
            cmp($sformatf("wrap co k%0d", k), co0, (k == 10));
            cmp($sformatf("wrap ovf k%0d", k), ovf0, (k >= 10));
            cmp($sformatf("wrap tc k%0d", k), tc0, (k % 10 == 9));
        end

        // Reset asserted between edges with ovf set and a saturate co pending
        repeat (5) step();
        cmp("pre-rst wrap q", dq(0), 7);
        cmp("pre-rst sat co", co1, 1);
        #2 rst = 1'b1;
        #1;
        cmp("async rst wrap q", dq(0), 0);
        cmp("async rst wrap ovf", ovf0, 0);
        cmp("async rst sat q", dq(1), 0);
        cmp("async rst sat co", co1, 0);
        cmp("async rst sat ovf", ovf1, 0);
        step();
        rst = 1'b0;
        step();
        cmp("post-rst q", dq(0), 1);
        cmp("post-rst ovf", ovf0, 0);

        // Load 2 then down-count into the saturating floor
        en = 0; ld = 1; d4 = 2; d8 = 2;
        step();
        cmp("sat ld q", dq(1), 2);
        ld = 0; en = 1; up = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            cmp($sformatf("sat dn q k%0d", k), dq(1), (k >= 2) ? 0 : 2 - k);
            cmp($sformatf("sat dn co k%0d", k), co1, (k >= 3));
            cmp($sformatf("sat dn ovf k%0d", k), ovf1, (k >= 3));
        end

        // Out-of-range load clamps; clr beats ld
        ld = 1; en = 1; up = 1; d4 = 13; d8 = 13;
        step();
        cmp("clamp q", dq(0), 9);
        cmp("clamp ovf", ovf0, 1);
        cmp("clamp co", co0, 0);
        clr = 1; d4 = 5; d8 = 5;
        step();
        cmp("clr>ld q", dq(0), 0);
        cmp("clr>ld ovf", ovf0, 0);
        clr = 0;

        // ovf_clr on the same edge as a wrap: set wins
        ld = 1; en = 0; d4 = 9; d8 = 9;
        step();
        cmp("ld9 q", dq(0), 9);
        ld = 0; en = 1; up = 1; ovf_clr = 1;
        step();
        cmp("collide q", dq(0), 0);
        cmp("collide co", co0, 1);
        cmp("collide ovf", ovf0, 1);
        en = 0;
        step();
        cmp("ovf_clr ovf", ovf0, 0);
        cmp("ovf_clr co", co0, 0);
        ovf_clr = 0;

        // Full 8-bit range: down from 0 wraps to 255
        clr = 1;
        step();
        clr = 0; up = 0;
        #1;
        cmp("full tc q0 dn", tc2, 1);
        en = 1;
        step();
        cmp("full q", dq(2), 255);
        cmp("full co", co2, 1);
        cmp("full tc q255 dn", tc2, 0);
        up = 1;
        #1;
        cmp("full tc q255 up", tc2, 1);
        en = 0;

        // Randomised traffic, checked every cycle by the model compare
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            clr     = ($urandom_range(0, 31) == 0);
            ld      = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            ovf_clr = ($urandom_range(0, 15) == 0);
            d4      = 4'($urandom_range(0, 15));
            d8      = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            step();
        end
        rst = 0; clr = 0; ld = 0; en = 0; ovf_clr = 0;
        step();
        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
